// File: rtl/cram_arb_pkg.sv
// cram_arb_pkg
// Shared types and default sizes for the cartridge RAM arbiter.
//   arb_state_t : arbiter sequencer states
//   arb_src_t   : which requester owns the current RAM access
//   CRAM_AW/DW  : default cram address / data widths
package cram_arb_pkg;

  localparam int CRAM_AW = 17;
  localparam int CRAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DATA,
    DONE
  } arb_state_t;

  typedef enum logic {
    SRC_MAP,
    SRC_BK
  } arb_src_t;

endpackage

// File: rtl/cram_req_latch.sv
// cram_req_latch
// Holds one mapper request that could not be started immediately, and
// flags when a newer request replaces one that never got to the RAM.
// Ports:
//   clk_sys, reset            clock, async active-high reset
//   m_req/m_we/m_addr/m_wdata  mapper request pulse and command
//   bypass                    arbiter idle: the request goes straight to ACC
//   start                     pending request is in its ACC cycle (clears pend)
//   pend, p_we, p_addr, p_wdata  pending command
//   m_overrun                 one-cycle pulse on overwrite of an unstarted request
module cram_req_latch
  import cram_arb_pkg::*;
#(
  parameter int AW = CRAM_AW,
  parameter int DW = CRAM_DW
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  input  logic          bypass,
  input  logic          start,
  output logic          pend,
  output logic          p_we,
  output logic [AW-1:0] p_addr,
  output logic [DW-1:0] p_wdata,
  output logic          m_overrun
);

  logic load;

  assign load = m_req && !bypass;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend      <= 1'b0;
      p_we      <= 1'b0;
      p_addr    <= '0;
      p_wdata   <= '0;
      m_overrun <= 1'b0;
    end else begin
      // A pending request already in its ACC cycle has been started, so a
      // new m_req then is not an overrun.
      m_overrun <= m_req && pend && !start;
      if (load) begin
        pend    <= 1'b1;
        p_we    <= m_we;
        p_addr  <= m_addr;
        p_wdata <= m_wdata;
      end else if (start) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cram_arbiter.sv
// cram_arbiter
// Single-port cram arbiter/sequencer between mapper register accesses and the
// battery-backup loader/saver. Mapper traffic has priority; one access runs
// at a time through a one-cycle-latency synchronous RAM port.
// Optional feature: define CRAM_ARB_DIRTY_EN to track mapper writes in dirty.
// Ports:
//   clk_sys, reset                     clock, async active-high reset
//   m_req/m_we/m_addr/m_wdata          mapper request (single-cycle pulse)
//   m_rdata, m_rvalid, m_overrun       mapper read data/valid, overwrite flag
//   bk_req/bk_we/bk_addr/bk_wdata      backup request (level until bk_ack)
//   bk_ack, bk_rdata                   backup completion and read data
//   bk_clr_dirty                       clear dirty (CRAM_ARB_DIRTY_EN only)
//   ram_addr/ram_we/ram_wdata/ram_rdata  cram port
//   busy, dirty                        status
//
// state | meaning
// IDLE  | waiting; picks mapper (pending or same-cycle) before backup
// ACC   | address/data/we on the RAM port for one cycle
// DATA  | RAM read data available; captured for the owning source
// DONE  | m_rvalid (mapper read) or bk_ack (backup) pulse
module cram_arbiter
  import cram_arb_pkg::*;
#(
  parameter int AW = CRAM_AW,
  parameter int DW = CRAM_DW
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic [DW-1:0] m_rdata,
  output logic          m_rvalid,
  output logic          m_overrun,
  input  logic          bk_req,
  input  logic          bk_we,
  input  logic [AW-1:0] bk_addr,
  input  logic [DW-1:0] bk_wdata,
  output logic          bk_ack,
  output logic [DW-1:0] bk_rdata,
  input  logic          bk_clr_dirty,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic          dirty
);

  arb_state_t    state;
  arb_src_t      src;
  logic          cmd_we;
  logic          ack_d;
  logic          pend;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          bypass;
  logic          start;
  logic          pend_next;

  assign bypass = (state == IDLE);
  assign start  = (state == ACC) && (src == SRC_MAP);
  // Mirror of the latch's next pend value, so busy can be registered.
  assign pend_next = (m_req && !bypass) || (pend && !start);

  cram_req_latch #(.AW(AW), .DW(DW)) u_req_latch (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .bypass    (bypass),
    .start     (start),
    .pend      (pend),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .m_overrun (m_overrun)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src       <= SRC_MAP;
      cmd_we    <= 1'b0;
      ack_d     <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      m_rdata   <= '0;
      m_rvalid  <= 1'b0;
      bk_rdata  <= '0;
      bk_ack    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      m_rvalid <= 1'b0;
      bk_ack   <= 1'b0;
      ack_d    <= bk_ack;
      busy     <= pend_next;
      case (state)
        IDLE: begin
          if (m_req || pend) begin
            state <= ACC;
            src   <= SRC_MAP;
            busy  <= 1'b1;
            // A same-cycle request is newer than anything pending.
            if (m_req) begin
              ram_addr  <= m_addr;
              ram_we    <= m_we;
              ram_wdata <= m_wdata;
              cmd_we    <= m_we;
            end else begin
              ram_addr  <= p_addr;
              ram_we    <= p_we;
              ram_wdata <= p_wdata;
              cmd_we    <= p_we;
            end
          end else if (bk_req && !ack_d) begin
            // ack_d masks the stale bk_req level right after an ack.
            state     <= ACC;
            src       <= SRC_BK;
            busy      <= 1'b1;
            ram_addr  <= bk_addr;
            ram_we    <= bk_we;
            ram_wdata <= bk_wdata;
            cmd_we    <= bk_we;
          end
        end
        ACC: begin
          state <= DATA;
          busy  <= 1'b1;
        end
        DATA: begin
          state <= DONE;
          busy  <= 1'b1;
          if (src == SRC_MAP) begin
            if (!cmd_we) begin
              m_rdata  <= ram_rdata;
              m_rvalid <= 1'b1;
            end
          end else begin
            bk_rdata <= ram_rdata;
            bk_ack   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CRAM_ARB_DIRTY_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty <= 1'b0;
    end else if ((state == ACC) && (src == SRC_MAP) && cmd_we) begin
      dirty <= 1'b1;
    end else if (bk_clr_dirty) begin
      dirty <= 1'b0;
    end
  end
`else
  logic unused_clr_dirty;
  assign unused_clr_dirty = bk_clr_dirty;
  assign dirty = 1'b0;
`endif

endmodule

// File: tb/tb_cram_arbiter.sv
module tb_cram_arbiter;
  import cram_arb_pkg::*;

  localparam int AW = CRAM_AW;
  localparam int DW = CRAM_DW;
`ifdef CRAM_ARB_DIRTY_EN
  localparam logic DIRTY_EXP = 1'b1;
`else
  localparam logic DIRTY_EXP = 1'b0;
`endif

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          m_req = 1'b0, m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata;
  logic          m_rvalid, m_overrun;
  logic          bk_req = 1'b0, bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_wdata = '0;
  logic          bk_ack;
  logic [DW-1:0] bk_rdata;
  logic          bk_clr_dirty = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy, dirty;

  cram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_overrun(m_overrun),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
    .bk_ack(bk_ack), .bk_rdata(bk_rdata), .bk_clr_dirty(bk_clr_dirty),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .dirty(dirty)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, old data on read-during-write.
  logic [DW-1:0] mem    [0:2**AW-1];
  logic [DW-1:0] shadow [0:2**AW-1];
  always @(posedge clk_sys) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] bk_q[$];
  int rv_cnt = 0, rv_cyc = 0, ack_cnt = 0, we_cnt = 0, we_cyc = 0, ovr_cnt = 0;
  logic [AW-1:0] we_addr = '0;

  always @(negedge clk_sys) begin
    if (m_rvalid) begin
      rv_cnt++;
      rv_cyc = cyc;
      if (m_q.size() == 0) check("m_rvalid_unexpected", 0, 1);
      else check("m_rdata", m_rdata, m_q.pop_front());
    end
    if (bk_ack) begin
      ack_cnt++;
      if (bk_q.size() == 0) check("bk_ack_unexpected", 0, 1);
      else check("bk_rdata", bk_rdata, bk_q.pop_front());
    end
    if (ram_we) begin
      we_cnt++;
      we_cyc = cyc;
      we_addr = ram_addr;
    end
    if (m_overrun) ovr_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic m_issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int c);
    @(posedge clk_sys); #1;
    m_req = 1'b1; m_we = we; m_addr = a; m_wdata = d;
    c = cyc;
    if (we) shadow[a] = d;
    else m_q.push_back(shadow[a]);
    @(posedge clk_sys); #1;
    m_req = 1'b0;
  endtask

  task automatic bk_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int c);
    @(posedge clk_sys); #1;
    bk_req = 1'b1; bk_we = we; bk_addr = a; bk_wdata = d;
    c = cyc;
    bk_q.push_back(shadow[a]);
    if (we) shadow[a] = d;
  endtask

  task automatic bk_wait(output int c);
    c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (bk_ack) begin
        c = cyc;
        bk_req = 1'b0;
        return;
      end
    end
    check("bk_ack_timeout", 0, 1);
    bk_req = 1'b0;
  endtask

  initial begin
    int c, b, ac, w0, r0, o0;
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = DW'(i) ^ 8'hA5;
      shadow[i] = DW'(i) ^ 8'hA5;
    end

    #12;
    check("reset_outputs",
          {m_rdata, m_rvalid, m_overrun, bk_ack, bk_rdata, ram_addr, ram_we, ram_wdata, busy, dirty},
          64'd0);
    @(negedge clk_sys) reset = 1'b0;
    idle(2);

    // mapper write then read-back
    w0 = we_cnt;
    m_issue(1'b1, 17'h00012, 8'h5A, c);
    idle(4);
    check("wr_we_pulses", we_cnt - w0, 1);
    check("wr_we_cycle", we_cyc - c, 1);
    check("wr_addr", we_addr, 17'h00012);
    check("busy_idle", busy, 0);
    r0 = rv_cnt;
    m_issue(1'b0, 17'h00012, 8'h00, c);
    check("busy_active", busy, 1);
    idle(4);
    check("rd_latency", rv_cyc - c, 3);
    check("rd_count", rv_cnt - r0, 1);
    check("rd_hold", m_rdata, 8'h5A);

    // collision: backup read first, mapper write waits
    bk_start(1'b0, 17'h00040, 8'h00, b);
    m_issue(1'b1, 17'h00040, 8'h11, c);
    bk_wait(ac);
    check("col_ack_cycle", ac - b, 3);
    idle(5);
    check("col_write_after_ack", we_cyc > ac, 1);
    check("col_write_addr", we_addr, 17'h00040);
    bk_start(1'b0, 17'h00040, 8'h00, b);
    bk_wait(ac);
    check("col_readback", bk_rdata, 8'h11);
    idle(2);

    // simultaneous requests: mapper first
    @(posedge clk_sys); #1;
    m_req = 1'b1; m_we = 1'b0; m_addr = 17'h00100;
    m_q.push_back(shadow[17'h00100]);
    bk_req = 1'b1; bk_we = 1'b0; bk_addr = 17'h00200;
    bk_q.push_back(shadow[17'h00200]);
    b = cyc;
    @(posedge clk_sys); #1;
    m_req = 1'b0;
    bk_wait(ac);
    check("pri_rvalid_cycle", rv_cyc - b, 3);
    check("pri_ack_cycle", ac - b, 7);
    idle(2);

    // overrun during a backup access
    o0 = ovr_cnt;
    w0 = we_cnt;
    bk_start(1'b0, 17'h00300, 8'h00, b);
    @(posedge clk_sys); #1;
    m_req = 1'b1; m_we = 1'b1; m_addr = 17'h00001; m_wdata = 8'hC1;
    @(posedge clk_sys); #1;
    m_addr = 17'h00002; m_wdata = 8'hC2;
    shadow[17'h00002] = 8'hC2;
    @(posedge clk_sys); #1;
    m_req = 1'b0;
    bk_wait(ac);
    idle(6);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_writes", we_cnt - w0, 1);
    check("ovr_addr", we_addr, 17'h00002);
    m_issue(1'b0, 17'h00001, 8'h00, c);
    m_issue(1'b0, 17'h00002, 8'h00, c);
    idle(5);

    // reset during a write's ACC cycle
    m_issue(1'b1, 17'h00500, 8'hEE, c);
    check("pre_reset_we", ram_we, 1);
    #2 reset = 1'b1;
    #1;
    check("reset_we_drop", ram_we, 0);
    check("reset_mid_outputs",
          {m_rdata, m_rvalid, m_overrun, bk_ack, bk_rdata, ram_addr, ram_we, ram_wdata, busy, dirty},
          64'd0);
    @(negedge clk_sys) reset = 1'b0;
    idle(3);
    check("reset_busy", busy, 0);
    w0 = we_cnt;
    r0 = rv_cnt;
    idle(4);
    check("reset_no_access", (we_cnt - w0) + (rv_cnt - r0), 0);

    // dirty tracking
    m_issue(1'b1, 17'h00600, 8'h77, c);
    idle(3);
    check("dirty_set", dirty, DIRTY_EXP);
    @(posedge clk_sys); #1;
    m_req = 1'b1; m_we = 1'b1; m_addr = 17'h00601; m_wdata = 8'h78;
    shadow[17'h00601] = 8'h78;
    @(posedge clk_sys); #1;
    m_req = 1'b0;
    bk_clr_dirty = 1'b1;
    @(posedge clk_sys); #1;
    bk_clr_dirty = 1'b0;
    idle(2);
    check("dirty_set_wins", dirty, DIRTY_EXP);
    @(posedge clk_sys); #1;
    bk_clr_dirty = 1'b1;
    @(posedge clk_sys); #1;
    bk_clr_dirty = 1'b0;
    check("dirty_cleared", dirty, 0);

    idle(3);
    check("m_queue_drained", m_q.size(), 0);
    check("bk_queue_drained", bk_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
